// File: rtl/fifo1c_pkg.sv
// Shared types and elaboration helpers for the parametrised single-clock FIFO.
// Optional feature macro: FIFO1C_PARITY_EN (stored even parity, checked on read).
package fifo1c_pkg;

    // Status flags as seen by the FIFO user.
    typedef struct packed {
        logic empty;
        logic full;
        logic aempty;
        logic afull;
        logic ovf;
        logic udf;
    } fifo_stat_t;

    // Smallest w with 2**w >= depth.
    function automatic int clog2_depth(input int depth);
        for (int w = 0; w < 31; w++) begin
            if ((1 << w) >= depth) return w;
        end
        return 31;
    endfunction

    // Thresholds must leave a non-empty band between almost_empty and almost_full.
    function automatic bit thres_ok(input int aemp, input int aful, input int depth);
        return (aemp < aful) && (aful <= depth);
    endfunction

endpackage

// File: rtl/fifo1c_if.sv
// Handshake/status bundle between a FIFO user (master) and the FIFO (slave).
interface fifo1c_if #(
    parameter int DATA_WIDTH = 108,
    parameter int ADDR_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] data;
    logic                  wrreq;
    logic                  rdreq;
    logic                  highest_clr;
    logic [DATA_WIDTH-1:0] q;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   usedw;
    logic [ADDR_WIDTH:0]   highest_dw;
    logic                  overflow;
    logic                  underflow;
    logic                  ovf_sticky;
    logic                  udf_sticky;
    logic                  parity_err;

    modport master (
        output data, wrreq, rdreq, highest_clr,
        input  q, empty, full, almost_empty, almost_full, usedw, highest_dw,
               overflow, underflow, ovf_sticky, udf_sticky, parity_err
    );

    modport slave (
        input  data, wrreq, rdreq, highest_clr,
        output q, empty, full, almost_empty, almost_full, usedw, highest_dw,
               overflow, underflow, ovf_sticky, udf_sticky, parity_err
    );
endinterface

// File: rtl/ram1r1w_param.sv
// Simple dual-port RAM: one write port, one registered read port.
// A read of the address being written in the same cycle returns the old word.
module ram1r1w_param #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [WIDTH-1:0]      wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [WIDTH-1:0]      rdata
);
    logic [WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    // Storage array: never reset, the FIFO pointers keep stale slots unreadable.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read register: reset so in-flight data is dropped, holds when not enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/fifo1c_param.sv
// Parametrised single-clock FIFO, normal or show-ahead read mode.
// The RAM read register doubles as q (normal) or as the prefetched head word (show-ahead).
// Optional feature macro: FIFO1C_PARITY_EN adds a stored even-parity bit per word.
module fifo1c_param
    import fifo1c_pkg::*;
#(
    parameter int DATA_WIDTH = 108,
    parameter int ADDR_WIDTH = 4,
    parameter int AFUL_THRES = 15,
    parameter int AEMP_THRES = 1,
    parameter int SHOWAHEAD  = 0
) (
    input logic     clk,
    input logic     rst_n,
    fifo1c_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam int UW    = ADDR_WIDTH + 1;
    localparam logic [UW-1:0] DEPTH_U = UW'(DEPTH);
    localparam logic [UW-1:0] AFUL_U  = UW'(AFUL_THRES);
    localparam logic [UW-1:0] AEMP_U  = UW'(AEMP_THRES);
`ifdef FIFO1C_PARITY_EN
    localparam int RW = DATA_WIDTH + 1;
`else
    localparam int RW = DATA_WIDTH;
`endif

    if (!thres_ok(AEMP_THRES, AFUL_THRES, DEPTH) || clog2_depth(DEPTH) != ADDR_WIDTH) begin : g_bad_param
        $error("fifo1c_param: need AEMP_THRES < AFUL_THRES <= DEPTH");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [UW-1:0]         usedw, highest;
    logic                  head_vld;
    logic                  ovf, udf, ovf_stk, udf_stk;
    logic                  wr_ok, rd_ok, ram_re;
    logic [RW-1:0]         ram_wd, ram_rd;
    fifo_stat_t            stat;

    // Status decode from the usedw register (show-ahead empty tracks the head word).
    always_comb begin
        stat        = '0;
        stat.full   = (usedw == DEPTH_U);
        stat.empty  = (SHOWAHEAD != 0) ? !head_vld : (usedw == '0);
        stat.aempty = (usedw <= AEMP_U);
        stat.afull  = (usedw >= AFUL_U);
        stat.ovf    = ovf;
        stat.udf    = udf;
    end

    assign wr_ok = bus.wrreq && !stat.full;
    assign rd_ok = bus.rdreq && !stat.empty;

    // Normal mode reads on demand; show-ahead refills the head whenever it is
    // free or being popped and the RAM still holds an unfetched word.
    if (SHOWAHEAD != 0) begin : g_sa
        assign ram_re = (usedw != UW'(head_vld)) && (!head_vld || rd_ok);
    end else begin : g_norm
        assign ram_re = rd_ok;
    end

`ifdef FIFO1C_PARITY_EN
    assign ram_wd = {^bus.data, bus.data};
`else
    assign ram_wd = bus.data;
`endif

    ram1r1w_param #(.WIDTH(RW), .ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (ram_wd),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_rd)
    );

    // Pointers, word count and head-valid; rd_ptr moves whenever the RAM is read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            usedw    <= '0;
            head_vld <= 1'b0;
        end else begin
            if (wr_ok)  wr_ptr <= wr_ptr + 1'b1;
            if (ram_re) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   usedw <= usedw + 1'b1;
                2'b01:   usedw <= usedw - 1'b1;
                default: ;
            endcase
            if (ram_re)     head_vld <= 1'b1;
            else if (rd_ok) head_vld <= 1'b0;
        end
    end

    // Error pulses, sticky flags and the usedw high-water mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf     <= 1'b0;
            udf     <= 1'b0;
            ovf_stk <= 1'b0;
            udf_stk <= 1'b0;
            highest <= '0;
        end else begin
            ovf     <= bus.wrreq && stat.full;
            udf     <= bus.rdreq && stat.empty;
            ovf_stk <= (ovf_stk && !bus.highest_clr) || (bus.wrreq && stat.full);
            udf_stk <= (udf_stk && !bus.highest_clr) || (bus.rdreq && stat.empty);
            highest <= (bus.highest_clr || usedw > highest) ? usedw : highest;
        end
    end

`ifdef FIFO1C_PARITY_EN
    logic ld_d;

    // Marks the cycle in which the read register holds a freshly loaded word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ld_d <= 1'b0;
        else        ld_d <= ram_re;
    end

    assign bus.parity_err = ld_d && (^ram_rd);
`else
    assign bus.parity_err = 1'b0;
`endif

    assign bus.q            = ram_rd[DATA_WIDTH-1:0];
    assign bus.empty        = stat.empty;
    assign bus.full         = stat.full;
    assign bus.almost_empty = stat.aempty;
    assign bus.almost_full  = stat.afull;
    assign bus.usedw        = usedw;
    assign bus.highest_dw   = highest;
    assign bus.overflow     = stat.ovf;
    assign bus.underflow    = stat.udf;
    assign bus.ovf_sticky   = ovf_stk;
    assign bus.udf_sticky   = udf_stk;
endmodule
